// File: rtl/bpf_sweep_pkg.sv
// ---------------------------------------------------------------------------
// bpf_sweep_pkg
// Shared types and constants for the BPF sweep-and-lock scheduler.
//   sweep_state_t : scheduler states
//   SAMPLE_W      : width of the signed BPF output sample
//   acc_width()   : window accumulator width for a 2^meas_log2 window
// ---------------------------------------------------------------------------
package bpf_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    COMPARE,
    DONE,
    LOCK
  } sweep_state_t;

  localparam int SAMPLE_W = 14;

  // A 14-bit magnitude summed 2^meas_log2 times never needs more than
  // SAMPLE_W + meas_log2 bits (the largest magnitude is 8192 = 2^13).
  function automatic int acc_width(input int meas_log2);
    return SAMPLE_W + meas_log2;
  endfunction

endpackage

// File: rtl/bpf_sweep_lock_ctrl_amp_meas.sv
// ---------------------------------------------------------------------------
// bpf_amp_meas
// Magnitude-and-accumulate datapath for one measurement window.
// Ports:
//   clk1d25MHz : sample clock, one BPF sample per cycle
//   rst_n      : asynchronous active-low reset
//   clear      : synchronous clear of the running sum (wins over en)
//   en         : add |sample| to the running sum this cycle
//   sample     : two's-complement BPF output sample
//   sum        : running sum of magnitudes
// ---------------------------------------------------------------------------
module bpf_amp_meas
  import bpf_sweep_pkg::*;
#(
  parameter int MEAS_LOG2 = 10
) (
  input  logic                            clk1d25MHz,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            en,
  input  logic [SAMPLE_W-1:0]             sample,
  output logic [SAMPLE_W+MEAS_LOG2-1:0]   sum
);

  localparam int ACC_W = acc_width(MEAS_LOG2);

  logic [SAMPLE_W-1:0] mag;
  logic [ACC_W-1:0]    acc;

  // Two's-complement negate for negative samples. The result is read as
  // unsigned, so the most negative sample maps to 8192 without saturating.
  assign mag = sample[SAMPLE_W-1] ? (~sample + SAMPLE_W'(1)) : sample;

  // Running window sum; the scheduler holds clear during settling so the
  // first measurement cycle starts from zero.
  always_ff @(posedge clk1d25MHz or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(mag);
    end
  end

  assign sum = acc;

endmodule

// File: rtl/bpf_sweep_lock_ctrl.sv
// ---------------------------------------------------------------------------
// bpf_sweep_lock_ctrl
// Sweeps the excitation frequency word across a band, lets the BPF settle
// at each point, integrates |bpf_out| over a 2^MEAS_LOG2 window and finally
// parks the frequency word on the point with the largest window sum.
// Ports:
//   clk1d25MHz : 1.25 MHz sample clock
//   rst_n      : asynchronous active-low reset
//   start      : level-sampled, starts a sweep from IDLE or LOCK
//   abort      : forces IDLE from any state, datapath values are held
//   bpf_out    : signed 14-bit BPF output sample
//   freq_word  : frequency word to the excitation DDS
//   busy       : high in SETTLE, MEASURE and COMPARE
//   locked     : high in LOCK
//   done       : one-cycle pulse on the first LOCK cycle
//   best_amp   : largest window sum of the current or last sweep
//   best_freq  : frequency word that produced best_amp
// ---------------------------------------------------------------------------
module bpf_sweep_lock_ctrl
  import bpf_sweep_pkg::*;
#(
  parameter int          FW         = 24,
  parameter logic [FW-1:0] F_START  = 24'd0,
  parameter logic [FW-1:0] F_STOP   = 24'd1000,
  parameter logic [FW-1:0] F_STEP   = 24'd100,
  parameter int          SETTLE_CYC = 256,
  parameter int          MEAS_LOG2  = 10
) (
  input  logic                          clk1d25MHz,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [SAMPLE_W-1:0]           bpf_out,
  output logic [FW-1:0]                 freq_word,
  output logic                          busy,
  output logic                          locked,
  output logic                          done,
  output logic [SAMPLE_W+MEAS_LOG2-1:0] best_amp,
  output logic [FW-1:0]                 best_freq
);

  localparam int ACC_W    = acc_width(MEAS_LOG2);
  localparam int MEAS_LEN = 1 << MEAS_LOG2;
  localparam int CNT_MAX  = (SETTLE_CYC > MEAS_LEN) ? SETTLE_CYC : MEAS_LEN;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  // Counters are loaded with length-1 and phases end when they reach zero.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MEAS_LOAD   = CNT_W'(MEAS_LEN - 1);

  sweep_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [FW-1:0]    freq_nxt;
  logic [ACC_W-1:0] best_amp_nxt;
  logic [FW-1:0]    best_freq_nxt;
  logic             done_q, done_nxt;
  logic             acc_clear, acc_en;
  logic [ACC_W-1:0] acc_sum;
  logic [FW:0]      step_sum;
  logic             last_point;
  logic             new_best;

  bpf_amp_meas #(
    .MEAS_LOG2 (MEAS_LOG2)
  ) u_amp_meas (
    .clk1d25MHz (clk1d25MHz),
    .rst_n      (rst_n),
    .clear      (acc_clear),
    .en         (acc_en),
    .sample     (bpf_out),
    .sum        (acc_sum)
  );

  // The next-point test is done one bit wider than the word so that a step
  // wrapping past 2^FW is seen as beyond F_STOP and ends the sweep.
  assign step_sum   = {1'b0, freq_word} + {1'b0, F_STEP};
  assign last_point = step_sum > {1'b0, F_STOP};

  // Strictly greater: on a tie the earlier (lower) frequency is kept.
  assign new_best   = acc_sum > best_amp;

  // State and datapath registers.
  always_ff @(posedge clk1d25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      freq_word <= F_START;
      best_amp  <= '0;
      best_freq <= F_START;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      freq_word <= freq_nxt;
      best_amp  <= best_amp_nxt;
      best_freq <= best_freq_nxt;
      done_q    <= done_nxt;
    end
  end

  // Next-state and datapath update logic. abort is applied last so that it
  // overrides every transition and freezes the frequency/best registers.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    freq_nxt      = freq_word;
    best_amp_nxt  = best_amp;
    best_freq_nxt = best_freq;
    done_nxt      = 1'b0;
    acc_clear     = 1'b0;
    acc_en        = 1'b0;

    case (state)
      IDLE, LOCK: begin
        if (start) begin
          state_nxt     = SETTLE;
          freq_nxt      = F_START;
          best_amp_nxt  = '0;
          best_freq_nxt = F_START;
          cnt_nxt       = SETTLE_LOAD;
        end
      end

      SETTLE: begin
        acc_clear = 1'b1;
        if (cnt == '0) begin
          state_nxt = MEASURE;
          cnt_nxt   = MEAS_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      MEASURE: begin
        acc_en = 1'b1;
        if (cnt == '0) begin
          state_nxt = COMPARE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      COMPARE: begin
        if (new_best) begin
          best_amp_nxt  = acc_sum;
          best_freq_nxt = freq_word;
        end
        if (last_point) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SETTLE;
          freq_nxt  = step_sum[FW-1:0];
          cnt_nxt   = SETTLE_LOAD;
        end
      end

      // best_freq already includes the final COMPARE result here.
      DONE: begin
        state_nxt = LOCK;
        freq_nxt  = best_freq;
        done_nxt  = 1'b1;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (abort) begin
      state_nxt     = IDLE;
      cnt_nxt       = cnt;
      freq_nxt      = freq_word;
      best_amp_nxt  = best_amp;
      best_freq_nxt = best_freq;
      done_nxt      = 1'b0;
      acc_clear     = 1'b0;
      acc_en        = 1'b0;
    end
  end

  // Status outputs decode straight from the state register, so abort and
  // reset clear them together with the state.
  assign busy   = (state == SETTLE) || (state == MEASURE) || (state == COMPARE);
  assign locked = (state == LOCK);
  assign done   = done_q;

endmodule

// File: tb/tb_bpf_sweep_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bpf_sweep_lock_ctrl
// Directed bench for bpf_sweep_lock_ctrl with F_START=1000, F_STEP=100,
// SETTLE_CYC=4, MEAS_LOG2=3 (13 cycles per point). Three instances share the
// stimulus: dut_a (F_STOP=1500), dut_b (F_STOP=1550) and dut_c (F_STOP=1000,
// single point). bpf_out is generated from dut_a's frequency word.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bpf_sweep_lock_ctrl;

  localparam int FW = 24;
  localparam int AW = 17;

  localparam int M_ZERO     = 0;
  localparam int M_CONST100 = 1;
  localparam int M_PEAK1300 = 2;
  localparam int M_NEG8192  = 3;
  localparam int M_RAMP     = 4;
  localparam int M_TIE      = 5;

  typedef struct {
    int mode;
    int exp_amp;
    int exp_freq;
    int exp_amp_single;
  } vec_t;

  logic          clk1d25MHz = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [13:0]   bpf_out;

  logic [FW-1:0] fw_a, fw_b, fw_c;
  logic          busy_a, busy_b, busy_c;
  logic          locked_a, locked_b, locked_c;
  logic          done_a, done_b, done_c;
  logic [AW-1:0] amp_a, amp_b, amp_c;
  logic [FW-1:0] bfreq_a, bfreq_b, bfreq_c;

  int   checks = 0;
  int   errors = 0;
  int   mode;
  logic phase;

  int   dcnt_a, dcnt_b, dcnt_c;
  int   dcyc_a, dcyc_b, dcyc_c;
  logic [FW-1:0] max_b;

  vec_t vecs[5];

  always #400 clk1d25MHz = ~clk1d25MHz;

  bpf_sweep_lock_ctrl #(
    .FW(FW), .F_START(24'd1000), .F_STOP(24'd1500), .F_STEP(24'd100),
    .SETTLE_CYC(4), .MEAS_LOG2(3)
  ) dut_a (
    .clk1d25MHz(clk1d25MHz), .rst_n(rst_n), .start(start), .abort(abort),
    .bpf_out(bpf_out), .freq_word(fw_a), .busy(busy_a), .locked(locked_a),
    .done(done_a), .best_amp(amp_a), .best_freq(bfreq_a)
  );

  bpf_sweep_lock_ctrl #(
    .FW(FW), .F_START(24'd1000), .F_STOP(24'd1550), .F_STEP(24'd100),
    .SETTLE_CYC(4), .MEAS_LOG2(3)
  ) dut_b (
    .clk1d25MHz(clk1d25MHz), .rst_n(rst_n), .start(start), .abort(abort),
    .bpf_out(bpf_out), .freq_word(fw_b), .busy(busy_b), .locked(locked_b),
    .done(done_b), .best_amp(amp_b), .best_freq(bfreq_b)
  );

  bpf_sweep_lock_ctrl #(
    .FW(FW), .F_START(24'd1000), .F_STOP(24'd1000), .F_STEP(24'd100),
    .SETTLE_CYC(4), .MEAS_LOG2(3)
  ) dut_c (
    .clk1d25MHz(clk1d25MHz), .rst_n(rst_n), .start(start), .abort(abort),
    .bpf_out(bpf_out), .freq_word(fw_c), .busy(busy_c), .locked(locked_c),
    .done(done_c), .best_amp(amp_c), .best_freq(bfreq_c)
  );

  // Stimulus model: sample value as a function of the swept frequency.
  function automatic logic [13:0] stim_value(input int m, input logic [FW-1:0] f,
                                             input logic ph);
    logic [13:0] pos900;
    logic [13:0] neg900;
    pos900 = 14'd900;
    neg900 = 14'd0 - 14'd900;
    case (m)
      M_CONST100: return 14'd100;
      M_PEAK1300: return (f == 24'd1300) ? (ph ? pos900 : neg900) : 14'd100;
      M_NEG8192:  return 14'h2000;
      M_RAMP:     return 14'(f / 10);
      M_TIE:      return ((f == 24'd1100) || (f == 24'd1400)) ? (ph ? pos900 : neg900) : 14'd100;
      default:    return 14'd0;
    endcase
  endfunction

  // Advance to the next falling edge, then drive the next sample.
  task automatic tick();
    @(negedge clk1d25MHz);
    phase   = ~phase;
    bpf_out = stim_value(mode, fw_a, phase);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one full sweep with the given stimulus mode. Cycle n counts rising
  // edges after the edge that sampled start (n=0 is the first SETTLE cycle).
  task automatic applyStimulus(input int m);
    mode   = m;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    checkOutput("restart_busy", busy_a, 1);
    checkOutput("restart_locked", locked_a, 0);
    checkOutput("restart_freq", fw_a, 1000);
    checkOutput("restart_amp", amp_a, 0);
    dcnt_a = 0; dcnt_b = 0; dcnt_c = 0;
    dcyc_a = -1; dcyc_b = -1; dcyc_c = -1;
    max_b  = '0;
    for (int n = 1; n <= 110; n++) begin
      tick();
      if (done_a) begin dcnt_a++; if (dcyc_a < 0) dcyc_a = n; end
      if (done_b) begin dcnt_b++; if (dcyc_b < 0) dcyc_b = n; end
      if (done_c) begin dcnt_c++; if (dcyc_c < 0) dcyc_c = n; end
      if (busy_b && (fw_b > max_b)) max_b = fw_b;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    mode    = M_ZERO;
    phase   = 1'b0;
    bpf_out = 14'd0;

    // Hand-computed sweep outcomes over points 1000..1500 (8-sample windows).
    vecs[0] = '{mode: M_PEAK1300, exp_amp: 7200,  exp_freq: 1300, exp_amp_single: 800};
    vecs[1] = '{mode: M_NEG8192,  exp_amp: 65536, exp_freq: 1000, exp_amp_single: 65536};
    vecs[2] = '{mode: M_RAMP,     exp_amp: 1200,  exp_freq: 1500, exp_amp_single: 800};
    vecs[3] = '{mode: M_TIE,      exp_amp: 7200,  exp_freq: 1100, exp_amp_single: 800};
    vecs[4] = '{mode: M_ZERO,     exp_amp: 0,     exp_freq: 1000, exp_amp_single: 0};

    $display("[TB] reset and idle hold");
    repeat (3) tick();
    checkOutput("reset_freq", fw_a, 1000);
    checkOutput("reset_best_freq", bfreq_a, 1000);
    rst_n = 1'b1;
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
        tick();
        if (fw_a !== 24'd1000 || busy_a !== 1'b0 || locked_a !== 1'b0 ||
            amp_a !== '0 || done_a !== 1'b0)
          bad++;
      end
      checkOutput("idle_hold_bad_cycles", bad, 0);
    end
    checkOutput("idle_busy", busy_a, 0);
    checkOutput("idle_locked", locked_a, 0);
    checkOutput("idle_amp", amp_a, 0);

    $display("[TB] table-driven sweeps");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].mode);
      checkOutput("sweep_best_amp", amp_a, vecs[v].exp_amp);
      checkOutput("sweep_best_freq", bfreq_a, vecs[v].exp_freq);
      checkOutput("sweep_lock_freq", fw_a, vecs[v].exp_freq);
      checkOutput("sweep_locked", locked_a, 1);
      checkOutput("sweep_busy", busy_a, 0);
      checkOutput("sweep_done_count", dcnt_a, 1);
      // Six points of 13 cycles: last COMPARE at n=77, DONE 78, LOCK 79.
      checkOutput("sweep_done_cycle", dcyc_a, 79);
      checkOutput("wide_done_cycle", dcyc_b, 79);
      checkOutput("wide_last_point", max_b, 1500);
      checkOutput("wide_lock_freq", fw_b, vecs[v].exp_freq);
      // One point: COMPARE at n=12, DONE 13, LOCK 14.
      checkOutput("single_done_cycle", dcyc_c, 14);
      checkOutput("single_done_count", dcnt_c, 1);
      checkOutput("single_lock_freq", fw_c, 1000);
      checkOutput("single_best_amp", amp_c, vecs[v].exp_amp_single);
      checkOutput("single_locked", locked_c, 1);
    end

    $display("[TB] abort during third point");
    mode  = M_CONST100;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 60 && fw_a != 24'd1200; i++) tick();
    checkOutput("abort_reach_1200", fw_a, 1200);
    repeat (5) tick();
    checkOutput("abort_pre_busy", busy_a, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", busy_a, 0);
    checkOutput("abort_locked", locked_a, 0);
    checkOutput("abort_done", done_a, 0);
    checkOutput("abort_freq", fw_a, 1200);
    checkOutput("abort_best_amp", amp_a, 800);
    repeat (3) tick();
    checkOutput("abort_stays_idle", busy_a, 0);
    checkOutput("abort_freq_held", fw_a, 1200);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("abort_restart_freq", fw_a, 1000);
    checkOutput("abort_restart_busy", busy_a, 1);
    checkOutput("abort_restart_amp", amp_a, 0);

    $display("[TB] start ignored while busy");
    repeat (20) tick();
    checkOutput("busy_start_pre_freq", fw_a, 1100);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_start_freq", fw_a, 1100);
    checkOutput("busy_start_busy", busy_a, 1);
    begin
      int seen;
      seen = -1;
      for (int n = 22; n <= 120 && seen < 0; n++) begin
        tick();
        if (done_a) seen = n;
      end
      checkOutput("busy_start_done_cycle", seen, 79);
    end
    checkOutput("busy_start_best_freq", bfreq_a, 1000);
    checkOutput("busy_start_best_amp", amp_a, 800);

    $display("[TB] asynchronous reset mid-settle");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    checkOutput("pre_reset_freq", fw_a, 1100);
    checkOutput("pre_reset_amp", amp_a, 800);
    #100 rst_n = 1'b0;
    #50;
    checkOutput("async_reset_freq", fw_a, 1000);
    checkOutput("async_reset_busy", busy_a, 0);
    checkOutput("async_reset_locked", locked_a, 0);
    checkOutput("async_reset_done", done_a, 0);
    checkOutput("async_reset_amp", amp_a, 0);
    checkOutput("async_reset_best_freq", bfreq_a, 1000);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checkOutput("post_reset_idle_busy", busy_a, 0);
    checkOutput("post_reset_idle_locked", locked_a, 0);
    checkOutput("post_reset_idle_freq", fw_a, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
